rx_initiated_point_test_ctrl: RTL
=================================

# rx_initiated_point_test_ctrl

Controller for the RX-initiated D2C point test. The local receiver asks the link partner to drive mainband or valid-train patterns, compares them locally, and answers the partner's result request with the per-lane and valid results. It then closes the test with an end handshake. The block sits beside the TX-initiated point test inside the MBTRAIN/link-training sequencer and shares the same sideband message port and pattern-comparator controls.

## Interface
- TIMEOUT_CYCLES, 800000: cycles from leaving IDLE before the test is abandoned (8 ms at 100 MHz).
- CNT_W, 20: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.
- clk  in  1  block clock; single clock domain.
- rst  in  1  reset, asynchronous, active-high.
- i_en  in  1  test enable; held high for the whole test.
- i_mainband_or_valtrain_test  in  1  0 = mainband, 1 = valid-train.
- i_lfsr_or_perlane  in  1  0 = LFSR pattern, 1 = per-lane ID pattern.
- i_sideband_message  in  4  decoded received message code.
- i_sideband_message_valid  in  1  one-cycle strobe qualifying i_sideband_message.
- i_falling_edge_busy  in  1  one-cycle pulse: sideband accepted the outstanding message.
- i_comparison_results  in  16  mainband comparator per-lane pass bits.
- i_valid_result  in  1  valid-lane comparator pass bit.
- o_sideband_message  out  4  message code to send.
- o_valid  out  1  send request; held until i_falling_edge_busy.
- o_data_valid  out  1  o_sideband_data is meaningful (RESULT_RESP only).
- o_sideband_data  out  16  lane results carried by RESULT_RESP.
- o_msg_info  out  1  valid-lane result carried by RESULT_RESP.
- o_mainband_pattern_compartor_cw  out  2  00 off, 01 LFSR compare, 10 per-lane compare.
- o_comparison_valid_en  out  1  enables the valid-pattern comparator.
- o_mainband_lanes_result  out  16  latched local lane results.
- o_valid_result  out  1  latched local valid result.
- o_test_ack  out  1  test finished; held while i_en is high.
- o_timeout  out  1  test finished by timeout; qualifies o_test_ack.

## Operation
- Message codes: 0 NONE, 1 START_REQ, 2 START_RESP, 3 LFSR_CLR_REQ, 4 LFSR_CLR_RESP, 5 RESULT_REQ, 6 RESULT_RESP, 7 END_REQ, 8 END_RESP.
- FSM states: IDLE, SEND_START, WAIT_START, SEND_CLR, WAIT_CLR, COMPARE, SEND_RESULT, SEND_END, WAIT_END, DONE.
- IDLE → SEND_START when i_en is high.
- Each SEND_x state drives o_valid=1 with its code. On i_falling_edge_busy it advances to the matching WAIT_x state; SEND_RESULT advances to SEND_END.
- WAIT_START → SEND_CLR on a received START_RESP.
- WAIT_CLR → COMPARE on a received LFSR_CLR_RESP.
- WAIT_END → DONE on a received END_RESP.
- Received codes that do not match the current state are ignored.
- In COMPARE:
  - Mainband test: cw = {i_lfsr_or_perlane, ~i_lfsr_or_perlane} and o_comparison_valid_en = 0.
  - Valid-train test: cw = 00 and o_comparison_valid_en = 1.
  - On a received RESULT_REQ, latch i_comparison_results into o_mainband_lanes_result and i_valid_result into o_valid_result. For a valid-train test the latched lanes are forced to 0.
  - Comparators are disabled the cycle after the latch, then the FSM goes to SEND_RESULT.
- SEND_RESULT drives o_data_valid=1, o_sideband_data = latched lanes, o_msg_info = latched valid result.
- DONE drives o_test_ack=1.
- Timeout:
  - The counter clears in IDLE and increments every cycle in any other state except DONE.
  - When it reaches TIMEOUT_CYCLES-1 the FSM goes to DONE with o_timeout=1. Timeout takes priority over any simultaneous message.
- i_en low in any state → IDLE.

## Timing
- All outputs are registered. Reset value of every output is 0; FSM = IDLE, counter = 0.
- o_valid rises one cycle after entering a SEND state.
- o_valid drops in the cycle after the i_falling_edge_busy pulse. The next SEND drives o_valid no earlier than one cycle after that.
- A message strobe in the same cycle as i_falling_edge_busy is lost; the partner sends responses only after acceptance.
- The results latch occurs in the cycle after the RESULT_REQ strobe. o_valid for RESULT_RESP rises one cycle later.
- i_en falling: all outputs return to 0 and latched results clear one cycle later.
- Asynchronous rst mid-test: immediate return to reset values, with no end handshake.

## Structure
- Package rx_point_test_pkg: message-code localparams, state enum, comparator cw constants (CW_OFF, CW_LFSR, CW_PERLANE).
- Sub-module sb_send_holder: holds the code, data and msg_info with o_valid/o_data_valid until i_falling_edge_busy. It is reusable by the TX-initiated side.
- The FSM, counter and result latch stay in the top module.

## Test plan
- Mainband LFSR test with prompt responses, i_comparison_results=16'hA5F0 at RESULT_REQ:
  - sent codes are 1, 3, 6, 7 in order;
  - o_sideband_data=16'hA5F0 with o_data_valid=1 on the 6;
  - cw=01 only in COMPARE;
  - o_test_ack=1 and o_timeout=0.
- Per-lane mainband test: cw=10 during COMPARE and o_comparison_valid_en=0.
- Valid-train test with i_valid_result=1 and i_comparison_results=16'hFFFF:
  - o_comparison_valid_en=1 during COMPARE;
  - RESULT_RESP carries data 16'h0000 and o_msg_info=1.
- Partner never answers START_REQ, with TIMEOUT_CYCLES=50: o_test_ack=1 and o_timeout=1 exactly 50 cycles after leaving IDLE.
- Spurious END_RESP and RESULT_REQ while in WAIT_START: no state change and no latch.
- i_en dropped in COMPARE, then rst pulsed mid-SEND_END: outputs are 0 the next cycle (after i_en drop) and immediately (after rst); a re-enable starts again with START_REQ.

Source files
------------

// File: rtl/rx_point_test_pkg.sv
// rtl/rx_point_test_pkg.sv - shared codes, states and comparator controls for the RX-initiated point test
package rx_point_test_pkg;

  localparam logic [3:0] MSG_NONE          = 4'd0;
  localparam logic [3:0] MSG_START_REQ     = 4'd1;
  localparam logic [3:0] MSG_START_RESP    = 4'd2;
  localparam logic [3:0] MSG_LFSR_CLR_REQ  = 4'd3;
  localparam logic [3:0] MSG_LFSR_CLR_RESP = 4'd4;
  localparam logic [3:0] MSG_RESULT_REQ    = 4'd5;
  localparam logic [3:0] MSG_RESULT_RESP   = 4'd6;
  localparam logic [3:0] MSG_END_REQ       = 4'd7;
  localparam logic [3:0] MSG_END_RESP      = 4'd8;

  localparam logic [1:0] CW_OFF     = 2'b00;
  localparam logic [1:0] CW_LFSR    = 2'b01;
  localparam logic [1:0] CW_PERLANE = 2'b10;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SEND_START,
    ST_WAIT_START,
    ST_SEND_CLR,
    ST_WAIT_CLR,
    ST_COMPARE,
    ST_SEND_RESULT,
    ST_SEND_END,
    ST_WAIT_END,
    ST_DONE
  } state_t;

  // Code that a SEND state puts on the sideband; NONE everywhere else.
  function automatic logic [3:0] send_code(input state_t s);
    case (s)
      ST_SEND_START:  return MSG_START_REQ;
      ST_SEND_CLR:    return MSG_LFSR_CLR_REQ;
      ST_SEND_RESULT: return MSG_RESULT_RESP;
      ST_SEND_END:    return MSG_END_REQ;
      default:        return MSG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/sb_send_holder.sv
// rtl/sb_send_holder.sv - holds an outgoing sideband message until the sideband accepts it
module sb_send_holder #(
  parameter int CODE_W = 4,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_req,
  input  logic [CODE_W-1:0] i_code,
  input  logic              i_data_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_msg_info,
  input  logic              i_falling_edge_busy,
  output logic [CODE_W-1:0] o_sideband_message,
  output logic              o_valid,
  output logic              o_data_valid,
  output logic [DATA_W-1:0] o_sideband_data,
  output logic              o_msg_info
);

  // A request loads only while nothing is outstanding, so after an acceptance
  // the line stays low for at least one cycle before the next message.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_sideband_message <= '0;
      o_valid            <= 1'b0;
      o_data_valid       <= 1'b0;
      o_sideband_data    <= '0;
      o_msg_info         <= 1'b0;
    end else if (i_clear || (o_valid && i_falling_edge_busy)) begin
      o_sideband_message <= '0;
      o_valid            <= 1'b0;
      o_data_valid       <= 1'b0;
      o_sideband_data    <= '0;
      o_msg_info         <= 1'b0;
    end else if (i_req && !o_valid) begin
      o_sideband_message <= i_code;
      o_valid            <= 1'b1;
      o_data_valid       <= i_data_valid;
      o_sideband_data    <= i_data;
      o_msg_info         <= i_msg_info;
    end
  end

endmodule

// File: rtl/rx_initiated_point_test_ctrl.sv
// rtl/rx_initiated_point_test_ctrl.sv - RX-initiated D2C point test sequencer with timeout and result latch
module rx_initiated_point_test_ctrl
  import rx_point_test_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 800000,
  parameter int CNT_W          = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  input  logic        i_mainband_or_valtrain_test,
  input  logic        i_lfsr_or_perlane,
  input  logic [3:0]  i_sideband_message,
  input  logic        i_sideband_message_valid,
  input  logic        i_falling_edge_busy,
  input  logic [15:0] i_comparison_results,
  input  logic        i_valid_result,
  output logic [3:0]  o_sideband_message,
  output logic        o_valid,
  output logic        o_data_valid,
  output logic [15:0] o_sideband_data,
  output logic        o_msg_info,
  output logic [1:0]  o_mainband_pattern_compartor_cw,
  output logic        o_comparison_valid_en,
  output logic [15:0] o_mainband_lanes_result,
  output logic        o_valid_result,
  output logic        o_test_ack,
  output logic        o_timeout
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              msg_ok, accepted, timeout_hit, in_send, send_result, result_req;
  logic [1:0]        cw_d;
  logic              valid_en_d, ack_d, timeout_d, vres_d;
  logic [15:0]       lanes_d;
  logic [3:0]        holder_code;

  // A strobe coinciding with an acceptance pulse is dropped.
  assign msg_ok      = i_sideband_message_valid && !i_falling_edge_busy;
  assign accepted    = o_valid && i_falling_edge_busy;
  assign timeout_hit = (state_q != ST_IDLE) && (state_q != ST_DONE) &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign in_send     = (state_q == ST_SEND_START) || (state_q == ST_SEND_CLR) ||
                       (state_q == ST_SEND_RESULT) || (state_q == ST_SEND_END);
  assign send_result = (state_q == ST_SEND_RESULT);
  assign result_req  = i_en && !timeout_hit && (state_q == ST_COMPARE) &&
                       msg_ok && (i_sideband_message == MSG_RESULT_REQ);
  assign holder_code = send_code(state_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!i_en) begin
      state_d = ST_IDLE;
    end else if (timeout_hit) begin
      state_d = ST_DONE;
    end else begin
      case (state_q)
        ST_IDLE:        state_d = ST_SEND_START;
        ST_SEND_START:  if (accepted) state_d = ST_WAIT_START;
        ST_WAIT_START:  if (msg_ok && i_sideband_message == MSG_START_RESP) state_d = ST_SEND_CLR;
        ST_SEND_CLR:    if (accepted) state_d = ST_WAIT_CLR;
        ST_WAIT_CLR:    if (msg_ok && i_sideband_message == MSG_LFSR_CLR_RESP) state_d = ST_COMPARE;
        ST_COMPARE:     if (result_req) state_d = ST_SEND_RESULT;
        ST_SEND_RESULT: if (accepted) state_d = ST_SEND_END;
        ST_SEND_END:    if (accepted) state_d = ST_WAIT_END;
        ST_WAIT_END:    if (msg_ok && i_sideband_message == MSG_END_RESP) state_d = ST_DONE;
        ST_DONE:        state_d = ST_DONE;
        default:        state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cw_d       = CW_OFF;
    valid_en_d = 1'b0;
    if (i_en && state_q == ST_COMPARE) begin
      if (!i_mainband_or_valtrain_test) cw_d = i_lfsr_or_perlane ? CW_PERLANE : CW_LFSR;
      else                              valid_en_d = 1'b1;
    end
    ack_d     = i_en && (state_d == ST_DONE);
    timeout_d = i_en && (timeout_hit || (state_q == ST_DONE && o_timeout));
    lanes_d   = o_mainband_lanes_result;
    vres_d    = o_valid_result;
    if (!i_en) begin
      lanes_d = '0;
      vres_d  = 1'b0;
    end else if (result_req) begin
      lanes_d = i_mainband_or_valtrain_test ? 16'h0000 : i_comparison_results;
      vres_d  = i_valid_result;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_mainband_pattern_compartor_cw <= CW_OFF;
      o_comparison_valid_en           <= 1'b0;
      o_test_ack                      <= 1'b0;
      o_timeout                       <= 1'b0;
      o_mainband_lanes_result         <= '0;
      o_valid_result                  <= 1'b0;
    end else begin
      o_mainband_pattern_compartor_cw <= cw_d;
      o_comparison_valid_en           <= valid_en_d;
      o_test_ack                      <= ack_d;
      o_timeout                       <= timeout_d;
      o_mainband_lanes_result         <= lanes_d;
      o_valid_result                  <= vres_d;
    end
  end

  // Free-running in every active state; DONE freezes it, IDLE clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       cnt_q <= '0;
    else if (state_q == ST_IDLE)   cnt_q <= '0;
    else if (state_q != ST_DONE)   cnt_q <= cnt_q + CNT_W'(1);
  end

  sb_send_holder #(.CODE_W(4), .DATA_W(16)) u_send (
    .clk                 (clk),
    .rst                 (rst),
    .i_clear             (!i_en || timeout_hit || (state_q == ST_DONE)),
    .i_req               (in_send),
    .i_code              (holder_code),
    .i_data_valid        (send_result),
    .i_data              (send_result ? o_mainband_lanes_result : 16'h0000),
    .i_msg_info          (send_result && o_valid_result),
    .i_falling_edge_busy (i_falling_edge_busy),
    .o_sideband_message  (o_sideband_message),
    .o_valid             (o_valid),
    .o_data_valid        (o_data_valid),
    .o_sideband_data     (o_sideband_data),
    .o_msg_info          (o_msg_info)
  );

endmodule
